// File: rtl/fetch_queue_compact.sv
// Compacting instruction queue between decode and dispatch: sparse decode lanes
// are packed contiguously at the tail, and up to DISPATCH_WIDTH entries are presented at the head.
module fetch_queue_compact_lane #(
  parameter int FETCH_WIDTH = 8,
  parameter int LANE        = 0,
  parameter int PW          = 5
) (
  input  logic [FETCH_WIDTH-1:0] vec,
  input  logic [PW-1:0]          tail,
  output logic [PW-1:0]          idx
);
  // Only lanes below this one push it further from the tail.
  localparam logic [FETCH_WIDTH-1:0] MASK = FETCH_WIDTH'((64'd1 << LANE) - 64'd1);

  assign idx = tail + PW'($countones(vec & MASK));
endmodule

module fetch_queue_compact #(
  parameter int FETCH_WIDTH      = 8,
  parameter int DISPATCH_WIDTH   = 4,
  parameter int DEPTH            = 32,
  parameter int DATA_W           = 64,
  parameter int BR_BIT           = 0,
  parameter int PARTIAL_DISPATCH = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]              decodedVector_i,
  input  logic [FETCH_WIDTH*DATA_W-1:0]       decodedPacket_i,
  output logic                                stallFetch_o,
  output logic                                instBufferReady_o,
  output logic [DISPATCH_WIDTH-1:0]           dispValid_o,
  output logic [DISPATCH_WIDTH*DATA_W-1:0]    decodedPacket_o,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0] branchCount_o,
  output logic [$clog2(DEPTH):0]              count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DISPATCH_WIDTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [FETCH_WIDTH-1:0][DATA_W-1:0]    lane_data;
  logic [FETCH_WIDTH-1:0][PW-1:0]        wr_idx;
  logic [DISPATCH_WIDTH-1:0][DATA_W-1:0] slot;
  logic                                  push, ready;
  logic [CW-1:0]                         push_n, pop_n, avail;
  logic [DISPATCH_WIDTH-1:0]             disp_valid;
  logic [BW-1:0]                         br_cnt;

  assign lane_data = decodedPacket_i;

  // Threshold guarantees a full group always fits, so count never exceeds DEPTH.
  assign stallFetch_o = count > CW'(DEPTH - FETCH_WIDTH);
  assign push   = decodeReady_i & ~stallFetch_o;
  assign push_n = push ? CW'($countones(decodedVector_i)) : '0;

  assign avail = (count < CW'(DISPATCH_WIDTH)) ? count : CW'(DISPATCH_WIDTH);
  assign ready = (PARTIAL_DISPATCH != 0) ? (count != '0) : (count >= CW'(DISPATCH_WIDTH));
  assign pop_n = (ready & ~stall_i) ? avail : '0;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    fetch_queue_compact_lane #(.FETCH_WIDTH(FETCH_WIDTH), .LANE(k), .PW(PW)) u_lane (
      .vec  (decodedVector_i),
      .tail (tail),
      .idx  (wr_idx[k])
    );
  end

  for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_slot
    assign slot[j] = mem[head + PW'(j)];
  end

  always_comb begin
    disp_valid = '0;
    br_cnt     = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      disp_valid[j] = (PARTIAL_DISPATCH != 0) ? (CW'(j) < avail) : ready;
      br_cnt        = br_cnt + BW'(disp_valid[j] & slot[j][BR_BIT]);
    end
  end

  assign instBufferReady_o = ready;
  assign dispValid_o       = disp_valid;
  assign decodedPacket_o   = slot;
  assign branchCount_o     = br_cnt;
  assign count_o           = count;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= PW'({1'b0, head} + pop_n);
      tail  <= PW'({1'b0, tail} + push_n);
      count <= count + push_n - pop_n;
    end
  end

  // Storage is never cleared; flushed or reset cycles simply drop the write.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (decodedVector_i[k]) mem[wr_idx[k]] <= lane_data[k];
    end
  end
endmodule

// File: doc/fetch_queue_compact.md
# fetch_queue_compact

Parametrised instruction-buffer block that sits between the decode stage and the rename/dispatch stage. It decouples decode from dispatch with a circular queue. Each cycle it accepts up to FETCH_WIDTH decoded packets, given as a sparse valid vector. Valid lanes are compacted into contiguous entries in lane order, so sparse vectors leave no holes. It delivers up to DISPATCH_WIDTH packets per cycle from the head and has an optional partial-dispatch mode.

## Interface
- FETCH_WIDTH, 8, decoded packets offered per cycle (1..DEPTH/2).
- DISPATCH_WIDTH, 4, packets presented and popped per cycle (1..FETCH_WIDTH).
- DEPTH, 32, queue entries; power of two, at least 2*FETCH_WIDTH.
- DATA_W, 64, bits per decoded packet.
- BR_BIT, 0, bit index inside a packet that flags a control instruction.
- PARTIAL_DISPATCH, 0, dispatch mode: 0 = all-or-nothing, 1 = partial groups allowed.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  misprediction flush; empties the queue.
- stall_i  in  1  backend stall; blocks any pop.
- decodeReady_i  in  1  the decode group is valid this cycle.
- decodedVector_i  in  FETCH_WIDTH  per-lane valid bits.
- decodedPacket_i  in  FETCH_WIDTH*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- stallFetch_o  out  1  the queue cannot guarantee room for a full group.
- instBufferReady_o  out  1  a dispatch group is available.
- dispValid_o  out  DISPATCH_WIDTH  per-slot valid, thermometer coded from slot 0.
- decodedPacket_o  out  DISPATCH_WIDTH*DATA_W  slot j = entry head+j.
- branchCount_o  out  clog2(DISPATCH_WIDTH+1)  count of valid slots whose BR_BIT is set.
- count_o  out  clog2(DEPTH)+1  current occupancy.

## Operation
- State: headPtr and tailPtr (clog2(DEPTH) bits, wrap modulo DEPTH), count (clog2(DEPTH)+1 bits), and a DEPTH x DATA_W storage array.
- stallFetch_o = (count > DEPTH - FETCH_WIDTH). The output is combinational from count only.
- Push:
  - push = decodeReady_i & ~stallFetch_o.
  - pushN = popcount(decodedVector_i).
  - Valid lane k is written to entry tailPtr + (number of valid lanes below k).
  - tailPtr advances by pushN. Invalid lanes are never written.
  - Lanes offered while stallFetch_o = 1 are dropped; upstream must hold them.
- Available group:
  - avail = min(count, DISPATCH_WIDTH).
  - Mode 0: instBufferReady_o = (count >= DISPATCH_WIDTH); dispValid_o is all ones when ready, else 0.
  - Mode 1: instBufferReady_o = (count != 0); dispValid_o has its low avail bits set.
- Pop:
  - popN = instBufferReady_o & ~stall_i ? avail : 0.
  - headPtr advances by popN.
- Count update: count_next = count + pushN - popN, computed at full width. Overflow is impossible by construction of the stall threshold.
- Read path:
  - decodedPacket_o slot j is read combinationally from entry headPtr+j.
  - Invalid slots carry don't-care data; the bench must not check them.
  - branchCount_o counts valid slots only.
- No bypass: a packet written in cycle n is first visible at the head in cycle n+1.
- Priority: reset > flush_i > normal operation. Flush or reset clears headPtr, tailPtr and count, and drops any same-cycle push or pop. Storage contents are not cleared.

## Timing
- Reset values: stallFetch_o=0, instBufferReady_o=0, dispValid_o=0, branchCount_o=0, count_o=0. Packet outputs are undefined.
- Latency: push to earliest dispatch is 1 cycle. Pop takes effect at the edge; the next group is visible the following cycle.
- Simultaneous push and pop: both apply in the same edge; count nets out.
- Wrap-around: pushes and dispatch reads that cross entry DEPTH-1 continue at entry 0 with no bubble.
- Full: when count = DEPTH, stallFetch_o = 1 and pops continue normally.
- Empty: instBufferReady_o = 0, no pointer movement.
- stall_i = 1: outputs hold steady. Pushes continue while stallFetch_o = 0.
- Flush mid-stream: the queue is empty in the cycle after flush; instBufferReady_o = 0 that cycle.

## Test plan
- Reset: assert reset 2 cycles with decodeReady_i=1 and vector 8'hFF -> count_o=0, stallFetch_o=0, instBufferReady_o=0, dispValid_o=0 every cycle; nothing is written.
- Compaction (DEPTH=16, FW=8, DW=4, mode 0): one push, vector 8'b1010_0101, lane k data = k, stall_i=1 -> next cycle count_o=4, slots = {0,2,5,7}, dispValid_o=4'b1111.
- Full/stall (stall_i=1):
  - Push 8 valid -> count 8, stallFetch_o=0.
  - Push 8 -> count 16, stallFetch_o=1.
  - Third push is dropped; count stays 16.
  - Release stall_i -> count 12, then 8. stallFetch_o=0 once count <= 8.
- Mode comparison with count=3, stall_i=0:
  - Mode 0: instBufferReady_o=0, count holds at 3.
  - Mode 1: dispValid_o=4'b0111, branchCount_o equals the number of BR_BIT-set packets among those 3, count 0 next cycle.
- Wrap with simultaneous push/pop: start headPtr=14, tailPtr=2, count=4. Push 5 and pop 4 in the same cycle -> headPtr=2, tailPtr=7, count=5. Data order is preserved across the 15->0 wrap.
- Flush collision: count=10, flush_i=1 with a same-cycle push of 8 and pop of 4 -> next cycle count 0, head=tail=0, instBufferReady_o=0. A push on the following cycle is dispatched correctly from entry 0.
